dispatch_stage: RTL

- Registered dispatch stage between the renamer and the per-FU issue queues.
- Accepts one renamed instruction per cycle and steers it to the issue queue selected by `fu_sel`.
- Owns the PRN scoreboard: one ready bit per physical register. It supplies the per-operand ready flags the issue queues capture at insertion.
- Keeps the held instruction's ready flags current from FU wake-up broadcasts, so no wake-up is lost while it waits.

---
 rtl/ooo_pkg.sv | 20 ++
 rtl/prn_scoreboard.sv | 56 +++++
 rtl/dispatch_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Shared types and default widths for the out-of-order dispatch/issue slice.
package ooo_pkg;

  localparam int DEF_INST_ID_BITS = 6;
  localparam int DEF_PRN_BITS     = 6;
  localparam int DEF_MAX_OPERANDS = 3;
  localparam int DEF_FU_COUNT     = 4;

  typedef struct packed {
    logic [DEF_INST_ID_BITS-1:0]                     inst_id;
    logic [31:0]                                     raw_instr;
    logic [63:0]                                     pc;
    logic [DEF_MAX_OPERANDS-1:0]                     prn_input_valid;
    logic [DEF_MAX_OPERANDS-1:0]                     prn_input_ready;
    logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]   prn_input;
    logic [DEF_MAX_OPERANDS-1:0]                     prn_output_valid;
    logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]   prn_output;
  } dispatch_payload_t;

endpackage

// File: rtl/prn_scoreboard.sv
// One ready bit per physical register: set by FU wake-ups, cleared on allocation,
// with per-operand lookups that bypass same-cycle wake-ups.
module prn_scoreboard #(
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]          set_valid_i,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn_i,
  input  logic                                           clr_en_i,
  input  logic [MAX_OPERANDS-1:0]                        clr_valid_i,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          clr_prn_i,
  input  logic [MAX_OPERANDS-1:0]                        lookup_valid_i,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          lookup_prn_i,
  output logic [MAX_OPERANDS-1:0]                        lookup_ready_o
);

  localparam int ENTRIES = 1 << PRN_BITS;

  logic [ENTRIES-1:0]      ready_q, ready_d;
  logic [MAX_OPERANDS-1:0] bypass_hit;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ready_d = ready_q;
    for (int k = 0; k < FU_COUNT; k++)
      for (int j = 0; j < MAX_OPERANDS; j++)
        if (set_valid_i[k][j]) ready_d[set_prn_i[k][j]] = 1'b1;
    // Clears are applied after sets so a new allocation beats a stale wake-up.
    if (clr_en_i)
      for (int i = 0; i < MAX_OPERANDS; i++)
        if (clr_valid_i[i]) ready_d[clr_prn_i[i]] = 1'b0;
    ready_d[0] = 1'b1;
  end

  // NOTE: the scoreboard is a flop vector, not RAM, so it takes the async reset to all-ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= '1;
    else        ready_q <= ready_d;
  end

  always_comb begin
    bypass_hit     = '0;
    lookup_ready_o = '0;
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      for (int k = 0; k < FU_COUNT; k++)
        for (int j = 0; j < MAX_OPERANDS; j++)
          if (set_valid_i[k][j] && set_prn_i[k][j] == lookup_prn_i[i]) bypass_hit[i] = 1'b1;
      lookup_ready_o[i] = lookup_valid_i[i] &&
                          (lookup_prn_i[i] == '0 || ready_q[lookup_prn_i[i]] || bypass_hit[i]);
    end
  end

endmodule

// File: rtl/dispatch_stage.sv
// Registered dispatch stage: captures one renamed instruction per cycle, steers it to
// its issue queue and tracks operand readiness through the PRN scoreboard.
module dispatch_stage
  import ooo_pkg::*;
#(
  parameter int INST_ID_BITS = DEF_INST_ID_BITS,
  parameter int PRN_BITS     = DEF_PRN_BITS,
  parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
  parameter int FU_COUNT     = DEF_FU_COUNT,
  parameter int FU_SEL_BITS  = $clog2(FU_COUNT)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [INST_ID_BITS-1:0]                        in_inst_id,
  input  logic [31:0]                                    in_raw_instr,
  input  logic [63:0]                                    in_pc,
  input  logic [FU_SEL_BITS-1:0]                         in_fu_sel,
  input  logic [MAX_OPERANDS-1:0]                        in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                        in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          in_prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]          set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  output logic [FU_COUNT-1:0]                            iq_inst_valid,
  input  logic [FU_COUNT-1:0]                            iq_queue_ready,
  output logic [INST_ID_BITS-1:0]                        out_inst_id,
  output logic [31:0]                                    out_raw_instr,
  output logic [63:0]                                    out_pc,
  output logic [MAX_OPERANDS-1:0]                        out_prn_input_valid,
  output logic [MAX_OPERANDS-1:0]                        out_prn_input_ready,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          out_prn_input,
  output logic [MAX_OPERANDS-1:0]                        out_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]          out_prn_output,
  output logic [31:0]                                    stall_cycles
);

  logic                    out_valid_q;
  logic [FU_SEL_BITS-1:0]  out_fu_q;
  dispatch_payload_t       payload_q, payload_d;
  logic [31:0]             stall_q;

  logic [FU_COUNT-1:0]     out_fu_hit, in_fu_hit;
  logic                    routed, sel_ready, accept, stall;
  logic [MAX_OPERANDS-1:0] src_ready, held_wake;

  always_comb begin
    out_fu_hit = '0;
    in_fu_hit  = '0;
    for (int k = 0; k < FU_COUNT; k++) begin
      out_fu_hit[k] = (out_fu_q == FU_SEL_BITS'(k));
      in_fu_hit[k]  = (in_fu_sel == FU_SEL_BITS'(k));
    end
  end

  // An unroutable selector has no queue to wait on, so the held slot simply empties.
  assign routed        = |out_fu_hit;
  assign sel_ready     = |(out_fu_hit & iq_queue_ready);
  assign in_ready      = !out_valid_q || sel_ready || !routed;
  assign accept        = in_valid && in_ready;
  assign stall         = out_valid_q && routed && !sel_ready;
  assign iq_inst_valid = {FU_COUNT{out_valid_q}} & out_fu_hit;

  prn_scoreboard #(
    .PRN_BITS     (PRN_BITS),
    .MAX_OPERANDS (MAX_OPERANDS),
    .FU_COUNT     (FU_COUNT)
  ) u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_valid_i    (set_prn_ready),
    .set_prn_i      (set_prn),
    .clr_en_i       (accept),
    .clr_valid_i    (in_prn_output_valid),
    .clr_prn_i      (in_prn_output),
    .lookup_valid_i (in_prn_input_valid),
    .lookup_prn_i   (in_prn_input),
    .lookup_ready_o (src_ready)
  );

  always_comb begin
    held_wake = '0;
    for (int i = 0; i < MAX_OPERANDS; i++)
      for (int k = 0; k < FU_COUNT; k++)
        for (int j = 0; j < MAX_OPERANDS; j++)
          if (payload_q.prn_input_valid[i] && set_prn_ready[k][j] &&
              set_prn[k][j] == payload_q.prn_input[i])
            held_wake[i] = 1'b1;
  end

  always_comb begin
    payload_d = payload_q;
    if (accept) begin
      payload_d.inst_id          = in_inst_id;
      payload_d.raw_instr        = in_raw_instr;
      payload_d.pc               = in_pc;
      payload_d.prn_input_valid  = in_prn_input_valid;
      payload_d.prn_input_ready  = src_ready;
      payload_d.prn_input        = in_prn_input;
      payload_d.prn_output_valid = in_prn_output_valid;
      payload_d.prn_output       = in_prn_output;
    end else if (out_valid_q) begin
      payload_d.prn_input_ready  = payload_q.prn_input_ready | held_wake;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_fu_q    <= '0;
      payload_q   <= '0;
      stall_q     <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_fu_q    <= in_fu_sel;
      end else if (sel_ready || !routed) begin
        out_valid_q <= 1'b0;
      end
      payload_q <= payload_d;
      if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign out_inst_id          = payload_q.inst_id;
  assign out_raw_instr        = payload_q.raw_instr;
  assign out_pc               = payload_q.pc;
  assign out_prn_input_valid  = payload_q.prn_input_valid;
  assign out_prn_input_ready  = payload_q.prn_input_ready;
  assign out_prn_input        = payload_q.prn_input;
  assign out_prn_output_valid = payload_q.prn_output_valid;
  assign out_prn_output       = payload_q.prn_output;
  assign stall_cycles         = stall_q;

  a_fu_sel_routable: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> |in_fu_hit);

endmodule
